sram_like_responder: RTL and testbench
======================================

# sram_like_responder

Responder end of the sram-like request/response interface that our pipeline fetch and memory stages drive. It accepts `req`/`addr` handshakes with `addr_ok`, performs reads and byte-masked writes on an internal word-addressed memory, and returns one in-order `data_ok` per accepted request after a configurable latency. It is the instruction/data memory model for pipeline simulation and the acceptance target for the fetch stage's cancel and buffering logic.

## Interface
- `MEM_AW`, 12: memory index width; capacity 2^MEM_AW 32-bit words; index = `addr[MEM_AW+1:2]`; upper address bits ignored (aliasing).
- `DEPTH`, 2: max outstanding accepted-but-unreturned requests (1..4).
- `ADDR_LAT`, 0: cycles `req` must be held before `addr_ok` may rise (0 = same cycle).
- `DATA_LAT`, 1: minimum cycles from handshake edge to `data_ok` (>=1).
- `RAND`, 0: 1 = pseudo-random extra stalls on both phases.
- `INIT_FILE`, "": if non-empty, memory loaded with `$readmemh` at time 0.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: request valid.
- `wr` in 1: 1 = write, 0 = read.
- `size` in 2: 0 byte, 1 half, 2 word; 3 treated as 2; informational only.
- `addr` in 32: byte address.
- `wstrb` in 4: write byte enables.
- `wdata` in 32: write data.
- `addr_ok` out 1: request accepted this cycle when `req & addr_ok`.
- `data_ok` out 1: one-cycle response pulse, registered.
- `rdata` out 32: read data, registered, valid only while `data_ok`.

## Operation
- Handshake = `req & addr_ok` in the same cycle. `addr_ok` is combinational: `req & ~reset & (hold_cnt >= ADDR_LAT) & (count < DEPTH) & gate_a`.
- `hold_cnt`: increments (saturating at ADDR_LAT) each cycle `req` is high without handshake; cleared on handshake or any cycle `req` is low. Master may drop `req` without handshake; nothing is queued or returned.
- `count` is the registered occupancy; full test uses registered `count`, so a pop in the same cycle does not free a slot until the next cycle.
- On handshake, write: memory bytes with `wstrb[i]=1` take `wdata[8i+7:8i]` at that edge; queue entry pushed with data 0. Read: word at index read at handshake (sees all earlier writes) and pushed into queue.
- Queue: in-order FIFO, `DEPTH` entries, each holding data and a ready time. Head retires when its age >= DATA_LAT and `gate_d`; retirement sets `data_ok`=1 and `rdata`=entry data for exactly the next cycle. No back-pressure on responses.
- `RAND=1`: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle; `gate_a = lfsr[0]`, `gate_d = lfsr[1]`. `RAND=0`: both gates 1.
- Reset: `count`, `hold_cnt`, queue pointers cleared, `data_ok`=0, `rdata`=0, LFSR reseeded; outstanding requests discarded (no response). Memory contents are not reset.

## Timing
- Handshake in cycle T, `RAND=0`: `data_ok` high in cycle T+DATA_LAT if the previous entry retired by T+DATA_LAT-1, otherwise in the cycle after the previous `data_ok`. Back-to-back `data_ok` allowed.
- Earliest `addr_ok` after `req` rises in cycle R: cycle R+ADDR_LAT.
- One handshake per cycle max; one `data_ok` per cycle max.
- Outputs in reset cycle and first post-reset cycle: `addr_ok`=0, `data_ok`=0, `rdata`=0.

## Test plan
- Reset: hold `reset` 3 cycles with `req`=1 -> `addr_ok`,`data_ok`,`rdata` all 0; first handshake no earlier than first cycle after reset deasserts.
- Write/read, ADDR_LAT=0 DATA_LAT=1: write 0x1c000010 data 0x12345678 strb 0xF; write same addr data 0x0000AB00 strb 0x2; read -> `data_ok` one cycle after read handshake, `rdata`=0x1234AB78; each write also gets one `data_ok`.
- Full, DEPTH=2 DATA_LAT=3: `req` held reading three addresses from cycle 0 -> `addr_ok` cycles 0,1; low cycles 2,3; handshake cycle 4; `data_ok` cycles 3,4,7 in request order.
- Withdrawal, ADDR_LAT=2: `req` high cycles 0-1 then low -> no `addr_ok`, no `data_ok`; `req` high from cycle 5 -> `addr_ok` cycle 7.
- Reset mid-flight, DATA_LAT=4: two reads accepted, `reset` one cycle before first response -> no `data_ok` ever; a write completed before reset remains readable afterward.
- Aliasing, MEM_AW=4: write 0xDEADBEEF to 0x40 -> read 0x00 returns 0xDEADBEEF; RAND=1 run of 200 random requests matches a scoreboard in order with one `data_ok` per handshake.

Source files
------------

// File: rtl/sram_like_responder.sv
// sram_like_responder
//   Responder side of the sram-like request/response interface. Accepts
//   req/addr handshakes (addr_ok), performs reads and byte-masked writes on
//   an internal word-addressed memory, and returns one in-order data_ok pulse
//   per accepted request after at least DATA_LAT cycles.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   req, wr, size    : request valid, write flag, access size (not used)
//   addr             : byte address; word index = addr[MEM_AW+1:2]
//   wstrb, wdata     : write byte enables and data
//   addr_ok          : combinational accept; handshake = req & addr_ok
//   data_ok, rdata   : registered one-cycle response pulse and read data
module sram_like_responder #(
    parameter int    MEM_AW    = 12,
    parameter int    DEPTH     = 2,
    parameter int    ADDR_LAT  = 0,
    parameter int    DATA_LAT  = 1,
    parameter int    RAND      = 0,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int AGE_W  = $clog2(DATA_LAT + 1);
    localparam int HOLD_W = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [AGE_W-1:0]  AGE_MAX  = AGE_W'(DATA_LAT);
    localparam logic [AGE_W-1:0]  AGE_RDY  = AGE_W'(DATA_LAT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ADDR_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam bit                BYPASS   = (DATA_LAT == 1);

    // age counts cycles since the handshake cycle (1 in the cycle after it)
    typedef struct packed {
        logic [31:0]      data;
        logic [AGE_W-1:0] age;
    } entry_t;

    logic [31:0]       mem [2**MEM_AW];
    entry_t            fifo [DEPTH];
    logic [MEM_AW-1:0] idx;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  fifo_cnt;   // entries waiting in the queue
    logic [CNT_W-1:0]  count;      // queue plus the response being presented
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic              gate_a, gate_d;
    logic              hold_ok, head_age_ok;
    logic              hs, pop, bypass, store;
    logic [31:0]       push_data;
    logic              unused_bits;

    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    assign idx = addr[MEM_AW+1:2];

    // Stall gates: 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shift form).
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign gate_a  = (RAND != 0) ? lfsr[0] : 1'b1;
    assign gate_d  = (RAND != 0) ? lfsr[1] : 1'b1;

    // Constant-true comparisons are kept out of elaboration entirely.
    if (ADDR_LAT == 0) begin : g_hold0
        assign hold_ok = 1'b1;
    end else begin : g_hold
        assign hold_ok = (hold_cnt >= HOLD_MAX);
    end

    if (DATA_LAT == 1) begin : g_age1
        assign head_age_ok = 1'b1;
    end else begin : g_age
        assign head_age_ok = (fifo[rd_ptr].age >= AGE_RDY);
    end

    // Full check uses registered count, so a slot freed by this cycle's
    // data_ok only becomes available next cycle.
    assign addr_ok   = req & ~reset & hold_ok & (count < CNT_MAX) & gate_a;
    assign hs        = addr_ok;
    assign push_data = wr ? 32'h0 : mem[idx];

    // With DATA_LAT=1 a request arriving at an empty queue must retire in its
    // own handshake cycle, so it skips the queue.
    assign pop    = (fifo_cnt != '0) & head_age_ok & gate_d;
    assign bypass = BYPASS & hs & (fifo_cnt == '0) & gate_d;
    assign store  = hs & ~bypass;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (hs && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (store && wr_ptr == PTR_W'(i)) begin
                fifo[i].data <= push_data;
                fifo[i].age  <= AGE_W'(1);
            end else if (fifo[i].age < AGE_MAX) begin
                fifo[i].age <= fifo[i].age + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            count    <= '0;
            hold_cnt <= '0;
            data_ok  <= 1'b0;
            rdata    <= 32'h0;
            lfsr     <= 16'hACE1;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};

            if (!req || hs)              hold_cnt <= '0;
            else if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);

            count    <= count + CNT_W'(hs) - CNT_W'(data_ok);
            fifo_cnt <= fifo_cnt + CNT_W'(store) - CNT_W'(pop);
            if (store) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);

            data_ok <= pop | bypass;
            rdata   <= pop ? fifo[rd_ptr].data : (bypass ? push_data : 32'h0);
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder. Five instances with different parameter
// sets share one clock; each has its own inputs, a reference memory and an
// in-order scoreboard of expected responses.
//   u0: DATA_LAT=1                     write/read merge, aliasing
//   u1: DEPTH=2 DATA_LAT=3             full / back-pressure timing
//   u2: ADDR_LAT=2                     request withdrawal, accept latency
//   u3: DATA_LAT=4                     reset with requests outstanding
//   u4: RAND=1 DEPTH=3 ADDR_LAT=1 DATA_LAT=2   random traffic
module tb_sram_like_responder;
    localparam int N = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst, req, wr, addr_ok, data_ok;
    logic [N-1:0][1:0]  size;
    logic [N-1:0][31:0] addr, wdata, rdata;
    logic [N-1:0][3:0]  wstrb;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        bit          known;
    } exp_t;

    typedef struct {
        logic        rst, rq, w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        aok, dok, rc;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar i = 0; i < N; i++) begin : g_dut
        localparam int DEP = (i == 4) ? 3 : 2;
        localparam int AL  = (i == 2) ? 2 : (i == 4) ? 1 : 0;
        localparam int DL  = (i == 1) ? 3 : (i == 3) ? 4 : (i == 4) ? 2 : 1;
        localparam int RN  = (i == 4) ? 1 : 0;

        sram_like_responder #(
            .MEM_AW(4), .DEPTH(DEP), .ADDR_LAT(AL), .DATA_LAT(DL), .RAND(RN), .INIT_FILE("")
        ) u_dut (
            .clk(clk), .reset(rst[i]), .req(req[i]), .wr(wr[i]), .size(size[i]),
            .addr(addr[i]), .wstrb(wstrb[i]), .wdata(wdata[i]),
            .addr_ok(addr_ok[i]), .data_ok(data_ok[i]), .rdata(rdata[i])
        );

        exp_t        q[$];
        logic [31:0] mdl [16];
        bit          mdl_v [16];
        int          hs_cnt = 0;
        int          dok_cnt = 0;

        always @(negedge clk) begin : mon
            exp_t e;
            int   ix;
            if (rst[i]) begin
                q.delete();
            end else begin
                if (data_ok[i]) begin
                    dok_cnt++;
                    if (q.size() == 0) begin
                        chk($sformatf("u%0d unexpected data_ok", i), 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        if (e.known) chk($sformatf("u%0d scoreboard rdata", i), rdata[i], e.d);
                    end
                end
                if (req[i] && addr_ok[i]) begin
                    hs_cnt++;
                    ix = int'(addr[i][5:2]);
                    if (wr[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[i][b]) mdl[ix][8*b +: 8] = wdata[i][8*b +: 8];
                        if (wstrb[i] == 4'hF) mdl_v[ix] = 1'b1;
                        q.push_back('{32'h0, 1'b1});
                    end else begin
                        q.push_back('{mdl[ix], mdl_v[ix]});
                    end
                end
            end
        end
    end

    task automatic tvp(input logic r, input logic rq_, input logic w_, input logic [31:0] a_,
                       input logic [3:0] s_, input logic [31:0] d_, input logic aok_,
                       input logic dok_, input logic rc_, input logic [31:0] rd_);
        vec_t t;
        t.rst = r; t.rq = rq_; t.w = w_; t.a = a_; t.s = s_; t.d = d_;
        t.aok = aok_; t.dok = dok_; t.rc = rc_; t.rd = rd_;
        tv.push_back(t);
    endtask

    task automatic run_vecs(input int k, input string tag);
        for (int j = 0; j < tv.size(); j++) begin
            rst[k] = tv[j].rst; req[k] = tv[j].rq; wr[k] = tv[j].w;
            addr[k] = tv[j].a; wstrb[k] = tv[j].s; wdata[k] = tv[j].d;
            @(negedge clk);
            chk($sformatf("%s[%0d] addr_ok", tag, j), {31'd0, addr_ok[k]}, {31'd0, tv[j].aok});
            chk($sformatf("%s[%0d] data_ok", tag, j), {31'd0, data_ok[k]}, {31'd0, tv[j].dok});
            if (tv[j].rc) chk($sformatf("%s[%0d] rdata", tag, j), rdata[k], tv[j].rd);
            @(posedge clk); #1;
        end
        tv.delete();
        rst[k] = 1'b0;
        req[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a request until accepted, bounded.
    task automatic xfer(input int k, input logic w_, input logic [31:0] a_,
                        input logic [3:0] s_, input logic [31:0] d_);
        logic got;
        got = 1'b0;
        req[k] = 1'b1; wr[k] = w_; addr[k] = a_; wstrb[k] = s_; wdata[k] = d_;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = addr_ok[k];
            @(posedge clk); #1;
        end
        req[k] = 1'b0;
        chk($sformatf("u%0d handshake within bound", k), {31'd0, got}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] a;
        rst = '1; req = '1; wr = '0; size = {N{2'd2}};
        addr = '0; wstrb = '0; wdata = '0;

        // Reset held with req high: nothing accepted, outputs quiet.
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("reset[%0d] addr_ok", c), {27'd0, addr_ok}, 32'd0);
            chk($sformatf("reset[%0d] data_ok", c), {27'd0, data_ok}, 32'd0);
            for (int k = 0; k < N; k++) chk($sformatf("reset[%0d] rdata u%0d", c, k), rdata[k], 32'd0);
            @(posedge clk); #1;
        end
        rst = '0; req = '0;
        @(negedge clk);
        chk("post-reset data_ok", {27'd0, data_ok}, 32'd0);
        for (int k = 0; k < N; k++) chk($sformatf("post-reset rdata u%0d", k), rdata[k], 32'd0);
        @(posedge clk); #1;

        // u0: write, partial overwrite, read merge; aliasing with MEM_AW=4.
        tvp(0,1,1,32'h1c000010,4'hF,32'h12345678, 1,0,0,32'h0);
        tvp(0,1,1,32'h1c000010,4'h2,32'h0000AB00, 1,1,1,32'h0);
        tvp(0,1,0,32'h1c000010,4'h0,32'h0,        1,1,1,32'h0);
        tvp(0,0,0,32'h0,       4'h0,32'h0,        0,1,1,32'h1234AB78);
        tvp(0,1,1,32'h00000040,4'hF,32'hDEADBEEF, 1,0,0,32'h0);
        tvp(0,1,0,32'h00000000,4'h0,32'h0,        1,1,1,32'h0);
        tvp(0,0,0,32'h0,       4'h0,32'h0,        0,1,1,32'hDEADBEEF);
        tvp(0,0,0,32'h0,       4'h0,32'h0,        0,0,0,32'h0);
        run_vecs(0, "wr_rd");

        // u1: queue full with DEPTH=2, DATA_LAT=3.
        xfer(1, 1'b1, 32'h100, 4'hF, 32'h11111111);
        xfer(1, 1'b1, 32'h104, 4'hF, 32'h22222222);
        xfer(1, 1'b1, 32'h108, 4'hF, 32'h33333333);
        idle(8);
        tvp(0,1,0,32'h100,4'h0,32'h0, 1,0,0,32'h0);
        tvp(0,1,0,32'h104,4'h0,32'h0, 1,0,0,32'h0);
        tvp(0,1,0,32'h108,4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,1,0,32'h108,4'h0,32'h0, 0,1,1,32'h11111111);
        tvp(0,1,0,32'h108,4'h0,32'h0, 1,1,1,32'h22222222);
        tvp(0,0,0,32'h0,  4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,0,0,32'h0,  4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,0,0,32'h0,  4'h0,32'h0, 0,1,1,32'h33333333);
        tvp(0,0,0,32'h0,  4'h0,32'h0, 0,0,0,32'h0);
        run_vecs(1, "full");

        // u2: ADDR_LAT=2, withdrawn request then accepted ones.
        tvp(0,1,0,32'h0,4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,1,0,32'h0,4'h0,32'h0, 0,0,0,32'h0);
        for (int c = 0; c < 3; c++) tvp(0,0,0,32'h0,4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,1,1,32'h8,4'hF,32'hCAFEF00D, 0,0,0,32'h0);
        tvp(0,1,1,32'h8,4'hF,32'hCAFEF00D, 0,0,0,32'h0);
        tvp(0,1,1,32'h8,4'hF,32'hCAFEF00D, 1,0,0,32'h0);
        tvp(0,0,0,32'h0,4'h0,32'h0, 0,1,1,32'h0);
        tvp(0,0,0,32'h0,4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,1,0,32'h8,4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,1,0,32'h8,4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,1,0,32'h8,4'h0,32'h0, 1,0,0,32'h0);
        tvp(0,0,0,32'h0,4'h0,32'h0, 0,1,1,32'hCAFEF00D);
        run_vecs(2, "withdraw");

        // u3: reset one cycle before the first response; memory survives.
        xfer(3, 1'b1, 32'h20, 4'hF, 32'h5A5AA5A5);
        idle(6);
        tvp(0,1,0,32'h20,4'h0,32'h0, 1,0,0,32'h0);
        tvp(0,1,0,32'h24,4'h0,32'h0, 1,0,0,32'h0);
        tvp(0,0,0,32'h0, 4'h0,32'h0, 0,0,0,32'h0);
        tvp(1,0,0,32'h0, 4'h0,32'h0, 0,0,1,32'h0);
        for (int c = 0; c < 6; c++) tvp(0,0,0,32'h0,4'h0,32'h0, 0,0,1,32'h0);
        tvp(0,1,0,32'h20,4'h0,32'h0, 1,0,0,32'h0);
        for (int c = 0; c < 3; c++) tvp(0,0,0,32'h0,4'h0,32'h0, 0,0,0,32'h0);
        tvp(0,0,0,32'h0, 4'h0,32'h0, 0,1,1,32'h5A5AA5A5);
        run_vecs(3, "reset_mid");

        // u4: random stalls; fill every word, then random traffic with
        // random upper address bits (aliasing) checked by the scoreboard.
        for (int j = 0; j < 16; j++) begin
            a = $urandom;
            a[5:2] = 4'(j);
            a[1:0] = 2'b00;
            xfer(4, 1'b1, a, 4'hF, $urandom);
        end
        for (int j = 0; j < 184; j++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            size[4] = 2'($urandom_range(0, 3));
            xfer(4, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            idle($urandom_range(0, 2));
        end
        for (int n = 0; n < 200 && g_dut[4].q.size() != 0; n++) idle(1);
        idle(4);
        chk("u4 handshake count", g_dut[4].hs_cnt, 32'd200);
        chk("u4 one data_ok per handshake", g_dut[4].dok_cnt, g_dut[4].hs_cnt);
        chk("u4 responses outstanding", g_dut[4].q.size(), 32'd0);
        chk("u0 responses outstanding", g_dut[0].q.size(), 32'd0);
        chk("u1 responses outstanding", g_dut[1].q.size(), 32'd0);
        chk("u2 responses outstanding", g_dut[2].q.size(), 32'd0);
        chk("u3 responses outstanding", g_dut[3].q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
